// File: rtl/pad_seq_pkg.sv
// Shared definitions for the pad sequencer: FSM state encoding and frame-shaping defaults.
package pad_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_GAP    = 2'd3
  } pad_state_t;

  localparam int FRAME_LEN_DEF  = 50;
  localparam int GAP_CYCLES_DEF = 2;

endpackage

// File: rtl/pad_seq_pipe.sv
// Two-stage output pipe: a hold stage that waits one cycle to learn whether a beat ends
// its frame (bubble detection), followed by the registered output stage.
module pad_seq_pipe #(
  parameter int W = 104
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                beat_valid_i,
  input  logic signed [W-1:0] beat_data_i,
  input  logic                beat_last_i,
  input  logic                bubble_i,
  output logic                valid_o,
  output logic signed [W-1:0] data_o,
  output logic                last_o
);

  logic                hold_valid;
  logic                hold_last;
  logic signed [W-1:0] hold_data;

  // hold_data is zeroed when empty so data_o is zero whenever valid_o is low
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      hold_data  <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      data_o     <= '0;
    end else begin
      hold_valid <= beat_valid_i;
      hold_last  <= beat_valid_i & beat_last_i;
      hold_data  <= beat_valid_i ? beat_data_i : '0;
      valid_o    <= hold_valid;
      last_o     <= hold_valid & (hold_last | bubble_i);
      data_o     <= hold_data;
    end
  end

endmodule

// File: rtl/pad_sequencer.sv
// Frame sequencer in front of the zero-pad stage: admits frames, enforces FRAME_LEN,
// terminates frames on bubbles, and inserts GAP_CYCLES dead cycles between frames.
module pad_sequencer
  import pad_seq_pkg::*;
#(
  parameter int BW         = 8,
  parameter int VECTOR_LEN = 13,
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  localparam int VECTOR_BW = BW * VECTOR_LEN
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        en_i,
  input  logic signed [VECTOR_BW-1:0] data_i,
  input  logic                        valid_i,
  input  logic                        last_i,
  output logic                        ready_o,
  output logic signed [VECTOR_BW-1:0] data_o,
  output logic                        valid_o,
  output logic                        last_o,
  output logic [15:0]                 frame_cnt_o,
  output logic                        err_short_o,
  output logic                        err_long_o,
  output logic                        err_bubble_o,
  output pad_state_t                  state_o
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST_C  = GAP_W'(GAP_CYCLES - 1);

  // Handshake: a beat transfers on a rising edge where valid_i & ready_o. ready_o is
  // registered, so in IDLE it follows en_i with one cycle of lag; there is no
  // downstream backpressure.
  pad_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ready_q, ready_d;
  logic             accept, emit, emit_last, bubble;
  logic             set_short, set_long, set_bubble;
  logic [15:0]      frame_cnt_q;

  assign accept  = valid_i & ready_q;
  assign cnt_inc = (state_q == ST_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    emit       = 1'b0;
    emit_last  = 1'b0;
    bubble     = 1'b0;
    set_short  = 1'b0;
    set_long   = 1'b0;
    set_bubble = 1'b0;
    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (accept) begin
          emit  = 1'b1;
          cnt_d = cnt_inc;
          if (last_i) begin
            emit_last = 1'b1;
            set_short = (cnt_inc != FRAME_LEN_C);
            state_d   = ST_GAP;
            gap_d     = '0;
          end else if (cnt_inc == FRAME_LEN_C) begin
            emit_last = 1'b1;
            set_long  = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            state_d = ST_STREAM;
          end
        end else if (state_q == ST_STREAM) begin
          bubble     = 1'b1;
          set_bubble = 1'b1;
          state_d    = ST_GAP;
          gap_d      = '0;
        end
      end
      ST_DRAIN: begin
        if (accept && last_i) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST_C) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE) ? en_i : (state_d == ST_STREAM || state_d == ST_DRAIN);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      ready_q      <= 1'b0;
      err_short_o  <= 1'b0;
      err_long_o   <= 1'b0;
      err_bubble_o <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      ready_q      <= ready_d;
      err_short_o  <= set_short;
      err_long_o   <= set_long;
      err_bubble_o <= set_bubble;
      frame_cnt_q  <= frame_cnt_q + {15'd0, valid_o & last_o};
    end
  end

  pad_seq_pipe #(.W(VECTOR_BW)) u_pipe (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .beat_valid_i(emit),
    .beat_data_i (data_i),
    .beat_last_i (emit_last),
    .bubble_i    (bubble),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .last_o      (last_o)
  );

  assign ready_o     = ready_q;
  assign frame_cnt_o = frame_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pad_sequencer.sv
// Bench for pad_sequencer: frame-level reference model feeding a scoreboard checked by a monitor.
module tb_pad_sequencer;
  import pad_seq_pkg::*;

  localparam int BW = 8;
  localparam int VL = 13;
  localparam int W  = BW * VL;
  localparam int FL = 4;
  localparam int GC = 2;

  logic         clk_i   = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         en_i    = 1'b0;
  logic [W-1:0] data_i  = '0;
  logic         valid_i = 1'b0;
  logic         last_i  = 1'b0;
  logic         ready_o, valid_o, last_o;
  logic [W-1:0] data_o;
  logic [15:0]  frame_cnt_o;
  logic         err_short_o, err_long_o, err_bubble_o;
  pad_state_t   state_o;

  pad_sequencer #(.BW(BW), .VECTOR_LEN(VL), .FRAME_LEN(FL), .GAP_CYCLES(GC)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
    .frame_cnt_o(frame_cnt_o), .err_short_o(err_short_o), .err_long_o(err_long_o),
    .err_bubble_o(err_bubble_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  int         t_q[$];
  logic [2:0] err_q[$];
  bit mon_en = 1'b0;
  int model_frames = 0;
  bit in_frame = 1'b0;
  bit seen_any = 1'b0;
  int gap_run = 0;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rand_beat();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // monitor
  always @(negedge clk_i) begin
    logic [W:0] e;
    int         t;
    logic [2:0] ev;
    if (!rst_n_i) begin
      model_frames = 0;
      in_frame     = 1'b0;
      seen_any     = 1'b0;
      gap_run      = 0;
    end else if (mon_en) begin
      chk("frame_cnt", frame_cnt_o, model_frames[15:0]);
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=valid data %0h required=no beat", data_o);
        end else begin
          e = exp_q.pop_front();
          t = t_q.pop_front();
          chk("data", data_o, e[W-1:0]);
          chk("last", last_o, e[W]);
          chk("latency", cyc, t);
          if (e[W]) model_frames++;
        end
        if (!in_frame && seen_any) chk("valid_gap", gap_run >= GC, 1);
        in_frame = !last_o;
        seen_any = 1'b1;
        gap_run  = 0;
      end else begin
        chk("idle_data_zero", data_o, 0);
        if (in_frame) begin
          checks++;
          errors++;
          $display("FAIL contiguity actual=valid_o low required=valid_o high mid-frame");
          in_frame = 1'b0;
        end
        gap_run++;
      end
      ev = {err_short_o, err_long_o, err_bubble_o};
      if (ev != 3'b000) begin
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err actual=%b required=none", ev);
        end else begin
          chk("err_kind", ev, err_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      last_i  = 1'b0;
    end
  endtask

  task automatic drive_beat(input logic [W-1:0] d, input logic l, input bit emit,
                            input bit lst_out, output int waited);
    int n = 0;
    @(negedge clk_i);
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    while (!ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    waited = n;
    if (!ready_o) chk("ready_timeout", ready_o, 1);
    else if (emit) begin
      exp_q.push_back({lst_out, d});
      t_q.push_back(cyc + 2);
    end
  endtask

  // kind 0: last_i on beat n (n<=FL); kind 1: last_i on beat n (n>FL); kind 2: bubble after n (n<FL)
  task automatic send_frame(input int kind, input int n, input bit drop_en, output int w0);
    int n_out;
    int w;
    logic [2:0] e;
    logic l;
    n_out = (kind == 1) ? FL : n;
    case (kind)
      0:       e = (n < FL) ? 3'b100 : 3'b000;
      1:       e = 3'b010;
      default: e = 3'b001;
    endcase
    if (e != 3'b000) err_q.push_back(e);
    w0 = 0;
    for (int i = 0; i < n; i++) begin
      l = (kind != 2) && (i == n - 1);
      if (drop_en && i == 1) en_i = 1'b0;
      drive_beat(rand_beat(), l, i < n_out, i == n_out - 1, w);
      if (i == 0) w0 = w;
    end
    en_i = 1'b1;
    if (kind == 2) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      last_i  = 1'b0;
    end
  endtask

  initial begin
    int w;
    int kind;
    int n;
    int frames;
    en_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("reset_ready", ready_o, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_last", last_o, 0);
    chk("reset_data", data_o, 0);
    chk("reset_frame_cnt", frame_cnt_o, 0);
    chk("reset_errs", {err_short_o, err_long_o, err_bubble_o}, 0);
    chk("reset_state", state_o, ST_IDLE);
    rst_n_i = 1'b1;
    mon_en  = 1'b1;

    send_frame(0, FL, 1'b0, w);
    idle(8);
    chk("normal_frame_cnt", frame_cnt_o, 1);

    for (int f = 0; f < 3; f++) begin
      send_frame(0, FL, 1'b0, w);
      if (f > 0) chk("b2b_ready_low_cycles", w, GC);
    end
    idle(8);

    send_frame(0, 2, 1'b0, w);
    idle(6);
    send_frame(1, FL + 2, 1'b0, w);
    idle(6);
    chk("long_frame_cnt", frame_cnt_o, 6);
    send_frame(2, 2, 1'b0, w);
    idle(6);
    chk("bubble_frame_cnt", frame_cnt_o, 7);

    mon_en = 1'b0;
    drive_beat(rand_beat(), 1'b0, 1'b0, 1'b0, w);
    drive_beat(rand_beat(), 1'b0, 1'b0, 1'b0, w);
    @(negedge clk_i);
    valid_i = 1'b0;
    #3 rst_n_i = 1'b0;
    #1;
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_last", last_o, 0);
    chk("async_rst_data", data_o, 0);
    chk("async_rst_ready", ready_o, 0);
    chk("async_rst_frame_cnt", frame_cnt_o, 0);
    chk("async_rst_state", state_o, ST_IDLE);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    mon_en  = 1'b1;
    send_frame(0, FL, 1'b0, w);
    idle(8);
    chk("post_reset_frame_cnt", frame_cnt_o, 1);

    frames = 1;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0:       n = $urandom_range(2, FL);
        1:       n = $urandom_range(FL + 1, FL + 3);
        default: n = $urandom_range(1, FL - 1);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk_i);
        en_i = 1'b0;
        idle($urandom_range(1, 4));
        en_i = 1'b1;
      end else begin
        idle($urandom_range(0, 3));
      end
      send_frame(kind, n, ($urandom_range(0, 3) == 0) && n >= 2, w);
      frames++;
    end
    idle(12);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    chk("final_frame_cnt", frame_cnt_o, frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
